// File: rtl/rpsc_fault_card.sv
// rpsc_fault_card: N-channel interlock card with glitch filters, hold/transparent latches and first-fault capture.
// Optional trip counter output enabled by defining RPSC_FAULT_TRIP_CNT_EN.
module rpsc_fault_card #(
    parameter int                N_CH       = 8,
    parameter logic [N_CH-1:0]   LATCH_MASK = N_CH'(8'h77),
    parameter int                FILT_CYC   = 4,
    parameter int                IDX_W      = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reset_hold_error,
    input  logic              LA_Test,
    input  logic [N_CH-1:0]   in,
    output logic [N_CH-1:0]   out,
    output logic [N_CH-1:0]   LA,
    output logic              any_fault,
    output logic              first_valid,
`ifdef RPSC_FAULT_TRIP_CNT_EN
    output logic [15:0]       trip_count,
`endif
    output logic [IDX_W-1:0]  first_idx
);
    logic [7:0]       r_cnt [N_CH];
    logic [N_CH-1:0]  w_filt;
    logic [N_CH-1:0]  w_next_out;
    logic [N_CH-1:0]  w_rise;
    logic [N_CH-1:0]  r_out;
    logic             r_first_valid;
    logic [IDX_W-1:0] r_first_idx;
    logic [IDX_W-1:0] w_low;
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign w_filt[i] = r_cnt[i] == 8'(FILT_CYC);
        always_ff @(posedge clk or posedge reset) begin
            if (reset) r_cnt[i] <= '0;
            else r_cnt[i] <= !in[i] ? 8'd0 : w_filt[i] ? r_cnt[i] : r_cnt[i] + 8'd1;
        end
    end
    // Set dominates the hold-error clear; transparent channels just follow the filter.
    assign w_next_out = w_filt | (r_out & LATCH_MASK & ~{N_CH{reset_hold_error}});
    assign w_rise     = w_next_out & ~r_out;
    always_comb begin
        w_low = '0;
        for (int k = N_CH - 1; k >= 0; k--)
            if (w_rise[k]) w_low = IDX_W'(k);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out         <= '0;
            r_first_valid <= 1'b0;
            r_first_idx   <= '0;
        end else begin
            r_out <= w_next_out;
            if (reset_hold_error) begin
                r_first_valid <= 1'b0;
                r_first_idx   <= '0;
            end else if (!r_first_valid && |w_rise) begin
                r_first_valid <= 1'b1;
                r_first_idx   <= w_low;
            end
        end
    end
`ifdef RPSC_FAULT_TRIP_CNT_EN
    logic [15:0] r_trip_count;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_trip_count <= '0;
        else if (|w_rise && r_trip_count != 16'hFFFF) r_trip_count <= r_trip_count + 16'd1;
    end
    assign trip_count = r_trip_count;
`endif
    assign out         = r_out;
    assign LA          = r_out | {N_CH{LA_Test}};
    assign any_fault   = |r_out;
    assign first_valid = r_first_valid;
    assign first_idx   = r_first_idx;
endmodule

// File: doc/rpsc_fault_card.md
Name: rpsc_fault_card

Overview:
- Parametrised N-channel interlock/fault card for the RPSC chassis. It generalises the fixed eight-flip-flop cards.
- Each channel has a digital glitch filter and a per-channel latch mode:
  - hold-error: sticky until `reset_hold_error`.
  - transparent: follows the filtered input.
- Each channel drives a lamp (LA) output, and all lamps share a lamp test.
- Adds first-fault capture, so the operator can see which interlock tripped first.

Parameters:
- N_CH, 8: number of fault channels (2..32).
- LATCH_MASK, 8'h77: per-channel mode. Bit i = 1 makes channel i hold-error (sticky); bit i = 0 makes it transparent.
- FILT_CYC, 4: consecutive high samples required before a fault is accepted (1..255).
- IDX_W, $clog2(N_CH): width of the first-fault index.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- reset_hold_error  input  1  synchronous, active-high clear of sticky channels and of the first-fault record.
- LA_Test  input  1  lamp test; forces all LA outputs high.
- in  input  N_CH  raw fault inputs, active-high, already synchronised upstream.
- out  output  N_CH  channel fault state (not affected by LA_Test).
- LA  output  N_CH  lamp drive, `out | {N_CH{LA_Test}}`, combinational.
- any_fault  output  1  OR of `out`, combinational.
- first_valid  output  1  a first fault has been captured.
- first_idx  output  IDX_W  index of the first channel to trip.

Behaviour:
- **Reset values.** Asynchronous reset forces the following; LA then reflects LA_Test only:
  - filter counters = 0
  - out = 0
  - any_fault = 0
  - first_valid = 0
  - first_idx = 0
- **Filter, per channel i.** An 8-bit counter `cnt[i]`:
  - in[i] = 1: `cnt` increments, saturating at FILT_CYC.
  - in[i] = 0: `cnt` clears to 0.
  - `filt[i] = (cnt[i] == FILT_CYC)`.
- **State register, per channel i** (`out[i]`):
  - Transparent channel: `out[i] <= filt[i]`.
  - Hold-error channel:
    - `filt[i] = 1` sets it.
    - Otherwise it clears only when `reset_hold_error = 1`.
    - Set dominates: if `filt[i] = 1` in the same cycle as `reset_hold_error`, out stays 1.
- **Latency.**
  - Assert: in high at FILT_CYC consecutive edges → out high after the next edge, i.e. FILT_CYC+1 edges from the first high sample.
  - Deassert, transparent channel: in low at one edge → out low after the following edge (2 edges).
  - A high pulse shorter than FILT_CYC samples never reaches out.
- **reset_hold_error on transparent channels.** No effect; they track filt.
- **First-fault capture.**
  - A rise is `out[i]` going 0→1 (`next_out & ~out`).
  - When `first_valid = 0` and at least one channel rises, on that edge:
    - `first_valid <= 1`
    - `first_idx <=` lowest rising index (lowest index wins on simultaneous trips).
  - While `first_valid = 1`, further rises are ignored.
  - `reset_hold_error = 1` clears `first_valid` and sets `first_idx = 0`; capture is suppressed in that same cycle.
  - If a hold-error channel is still set after the clear, it does not re-capture, because no rise occurs.
- **Async reset mid-filter.** Aborts the count; a fault needs a full FILT_CYC samples again.
- **LA_Test.** Does not alter out, any_fault, or the first-fault record.

Optional Feature:
- Macro: RPSC_FAULT_TRIP_CNT_EN.
- **Defined:**
  - Adds output port `trip_count`, output, 16 bits.
  - Increments by 1 on every edge where one or more channels rise, regardless of how many rise.
  - Saturates at 16'hFFFF.
  - Cleared only by `reset`; unaffected by `reset_hold_error`.
- **Undefined:** the port and its counter are absent; all other behaviour is identical.

Test Plan (N_CH=8, LATCH_MASK=8'h77, FILT_CYC=4):
1. **Glitch rejection.** in[0] high for 3 edges, then low → out stays 8'h00, first_valid = 0.
2. **Sticky latch and clear.** in[1] high for 4 edges, then low → out[1] = 1 after edge 5, and stays 1 after in drops. Pulse reset_hold_error for one cycle → out = 8'h00, first_valid = 0.
3. **Transparent channel.** in[3] high for 6 edges → out[3] = 1 from edge 5. in[3] low → out[3] = 0 two edges later. reset_hold_error has no effect on it.
4. **Simultaneous first fault.**
   - in[6] and in[2] rise together → first_idx = 2, first_valid = 1.
   - Later in[0] trips → first_idx stays 2.
   - reset_hold_error while in[2] is still high → first_valid = 0; out[2] stays 1; no re-capture.
5. **Lamp test.** LA_Test = 1 with out = 8'h02 → LA = 8'hFF, out = 8'h02. LA_Test = 0 → LA = 8'h02.
6. **Async reset.** Assert reset mid-count (cnt[5] = 3) → all outputs 0 immediately, without waiting for a clock. After release, in[5] needs 4 new high samples before out[5] sets. With RPSC_FAULT_TRIP_CNT_EN defined, trip_count = 0 after reset and 1 after that trip.
